// File: rtl/mem_dcache.sv
// mem_dcache: direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Loads hit combinationally; misses and every store go to main memory over a req/ack handshake.
module mem_dcache #(
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [63:0] address,
  input  logic [63:0] writeData,
  output logic [63:0] readData,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned LINES = 1 << IDX_W;
  localparam int unsigned TAG_W = 61 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_WDONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [63:0]      r_data [LINES];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_match;
  logic             w_fill;
  logic             w_upd;
  logic [2:0]       w_unused_lsb;

  assign w_idx        = address[IDX_W+2:3];
  assign w_tag        = address[63:IDX_W+3];
  assign w_match      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign mem_addr     = {address[63:3], 3'b000};
  assign mem_wdata    = writeData;
  assign w_unused_lsb = address[2:0];

  // State and valid bits; reset drops any outstanding request and invalidates every line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= '0;
    end else begin
      r_state <= w_next;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; they are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_rdata;
    end else if (w_upd) begin
      r_data[w_idx] <= writeData;
    end
  end

  always_comb begin
    w_next   = r_state;
    hit      = 1'b0;
    readData = '0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    w_fill   = 1'b0;
    w_upd    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MemWrite) begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          w_next  = S_WRITE;
        end else if (MemRead) begin
          if (w_match) begin
            hit      = 1'b1;
            readData = r_data[w_idx];
          end else begin
            mem_req = 1'b1;
            w_next  = S_FILL;
          end
        end else begin
          hit = 1'b1;
        end
      end
      S_FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_fill = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          w_upd  = w_match;
          w_next = S_WDONE;
        end
      end
      // One completed cycle so a still-asserted MemWrite is not reissued.
      S_WDONE: begin
        hit    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_dcache.sv
// tb_mem_dcache: directed table plus randomized operations checked against a line-level cache model
// and a sparse main-memory model; the bench plays the memory side of the handshake.
module tb_mem_dcache;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned NLINE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [63:0] address, writeData, readData;
  logic        hit, mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Reference state: per-index valid/line-address/data, plus sparse main memory.
  logic        m_valid [NLINE];
  logic [60:0] m_line  [NLINE];
  logic [63:0] m_data  [NLINE];
  logic [63:0] mem [logic [63:0]];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wd;
    int          dly;
    logic        early;
    logic        exp_hit0;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t tbl [11];

  mem_dcache #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .writeData(writeData), .readData(readData), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  function automatic int idx_of(input logic [63:0] a);
    return int'((a >> 3) % 64'(NLINE));
  endfunction

  function automatic logic model_hit(input logic [63:0] a);
    return m_valid[idx_of(a)] && (m_line[idx_of(a)] == a[63:3]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(NLINE); i++) m_valid[i] = 1'b0;
  endtask

  // One pipeline operation, checked cycle by cycle until the stage completes.
  task automatic run_op(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, input int dly, input logic early,
                        input logic exp_hit0, input logic [63:0] exp_rd);
    logic [63:0] a;
    a = {addr[63:3], 3'b000};
    MemRead = rd; MemWrite = wr; address = addr; writeData = wd;
    if (early) begin
      mem_ack = 1'b1;
      mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    @(negedge clk);
    if (!rd && !wr) begin
      chk1("idle_hit", hit, 1'b1);
      chk("idle_rdata", readData, 64'd0);
      chk1("idle_req", mem_req, 1'b0);
    end else if (wr) begin
      chk1("st_issue_hit", hit, 1'b0);
      chk1("st_issue_req", mem_req, 1'b1);
      chk1("st_issue_we", mem_we, 1'b1);
      chk("st_addr", mem_addr, a);
      chk("st_wdata", mem_wdata, wd);
      step();
      mem_ack = 1'b0;
      for (int k = 1; k <= dly; k++) begin
        if (k == dly) mem_ack = 1'b1;
        @(negedge clk);
        chk1("st_wait_hit", hit, 1'b0);
        chk1("st_wait_req", mem_req, 1'b1);
        chk1("st_wait_we", mem_we, 1'b1);
        step();
        mem_ack = 1'b0;
      end
      @(negedge clk);
      chk1("wdone_hit", hit, 1'b1);
      chk("wdone_rdata", readData, 64'd0);
      chk1("wdone_req", mem_req, 1'b0);
      mem[a] = wd;
      if (model_hit(a)) m_data[idx_of(a)] = wd;
    end else if (exp_hit0) begin
      chk1("ld_hit", hit, 1'b1);
      chk("ld_hit_data", readData, exp_rd);
      chk1("ld_hit_req", mem_req, 1'b0);
    end else begin
      chk1("ld_miss_hit", hit, 1'b0);
      chk1("ld_miss_req", mem_req, 1'b1);
      chk1("ld_miss_we", mem_we, 1'b0);
      chk("ld_miss_addr", mem_addr, a);
      step();
      mem_ack = 1'b0;
      for (int k = 1; k <= dly; k++) begin
        if (k == dly) begin
          mem_ack = 1'b1;
          mem_rdata = mem_rd(a);
        end
        @(negedge clk);
        chk1("fill_hit", hit, 1'b0);
        chk1("fill_req", mem_req, 1'b1);
        step();
        mem_ack = 1'b0;
        mem_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
      end
      @(negedge clk);
      chk1("ld_done_hit", hit, 1'b1);
      chk("ld_done_data", readData, exp_rd);
      chk1("ld_done_req", mem_req, 1'b0);
      m_valid[idx_of(a)] = 1'b1;
      m_line[idx_of(a)]  = a[63:3];
      m_data[idx_of(a)]  = mem_rd(a);
    end
    step();
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    logic [63:0] ra, rwd;
    logic        rrd, rwr, eh;
    logic [63:0] er;
    int          kind;

    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; address = '0; writeData = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_clear();
    mem[64'h40]  = 64'h0000_0000_DEAD_BEEF;
    mem[64'h440] = 64'h0000_0000_0000_5555;

    tbl[0]  = '{1'b1, 1'b0, 64'h40,  64'h0,    3, 1'b0, 1'b0, 64'hDEAD_BEEF};
    tbl[1]  = '{1'b1, 1'b0, 64'h45,  64'h0,    1, 1'b0, 1'b1, 64'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 1'b0, 64'h440, 64'h0,    2, 1'b0, 1'b0, 64'h5555};
    tbl[3]  = '{1'b1, 1'b0, 64'h40,  64'h0,    1, 1'b1, 1'b0, 64'hDEAD_BEEF};
    tbl[4]  = '{1'b0, 1'b1, 64'h40,  64'h1234, 2, 1'b0, 1'b0, 64'h0};
    tbl[5]  = '{1'b1, 1'b0, 64'h40,  64'h0,    1, 1'b0, 1'b1, 64'h1234};
    tbl[6]  = '{1'b0, 1'b1, 64'h80,  64'h77,   1, 1'b1, 1'b0, 64'h0};
    tbl[7]  = '{1'b1, 1'b0, 64'h80,  64'h0,    1, 1'b0, 1'b0, 64'h77};
    tbl[8]  = '{1'b1, 1'b1, 64'h100, 64'h99,   1, 1'b0, 1'b0, 64'h0};
    tbl[9]  = '{1'b1, 1'b0, 64'h100, 64'h0,    2, 1'b0, 1'b0, 64'h99};
    tbl[10] = '{1'b0, 1'b0, 64'h40,  64'h0,    1, 1'b0, 1'b1, 64'h0};

    #12;
    chk1("rst_hit", hit, 1'b1);
    chk("rst_rdata", readData, 64'd0);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].dly,
             tbl[i].early, tbl[i].exp_hit0, tbl[i].exp_rd);
    end

    // Reset while a fill is outstanding, then a stray ack once reset is released.
    MemRead = 1'b1; address = 64'h200;
    @(negedge clk);
    chk1("rf_issue_req", mem_req, 1'b1);
    step();
    @(negedge clk);
    chk1("rf_fill_req", mem_req, 1'b1);
    #1;
    rst_n = 1'b0; MemRead = 1'b0;
    model_clear();
    #1;
    chk1("rf_req_drop", mem_req, 1'b0);
    chk1("rf_hit", hit, 1'b1);
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 64'hFEED_FACE_0000_0001;
    @(negedge clk);
    chk1("rf_late_ack_req", mem_req, 1'b0);
    chk1("rf_late_ack_hit", hit, 1'b1);
    step();
    mem_ack = 1'b0;
    run_op(1'b1, 1'b0, 64'h200, 64'h0, 2, 1'b0, 1'b0, mem_rd(64'h200));
    run_op(1'b1, 1'b0, 64'h40, 64'h0, 1, 1'b0, 1'b0, mem_rd(64'h40));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      ra = (64'($urandom_range(0, 3)) << 7) | (64'($urandom_range(0, 15)) << 3)
         | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ra[63] = 1'b1;
      rwd = {$urandom, $urandom};
      rrd = (kind >= 1 && kind <= 6) || kind == 9;
      rwr = (kind >= 7);
      eh  = model_hit({ra[63:3], 3'b000});
      er  = eh ? m_data[idx_of(ra)] : mem_rd({ra[63:3], 3'b000});
      run_op(rrd, rwr, ra, rwd, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), eh, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
